// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel button debouncer:
//   - per-channel state encoding (bit 1 of the encoding is the debounced level)
//   - default timing constants for the 100 MHz board
//     (10 ms stable, 500 ms hold-to-repeat, 100 ms repeat period)
//   - helper to extract the debounced level from a state value
// Optional feature macro used by the design files: BTN_DEBOUNCE_REPEAT_EN.
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'b00,
        CONFIRM_HIGH = 2'b01,
        CONFIRM_LOW  = 2'b10,
        IDLE_HIGH    = 2'b11
    } ch_state_t;

    localparam int unsigned DEF_N_CH          = 4;
    localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;
    localparam int unsigned DEF_CNT_W         = 20;
    localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
    localparam int unsigned DEF_REP_W         = 26;

    // The encoding is chosen so that the MSB is the accepted level in every state:
    // CONFIRM_HIGH is still low, CONFIRM_LOW is still high.
    function automatic logic state_level(input ch_state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/btn_debounce_array_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_array_if
// Bundles the raw button inputs and the per-channel debounced outputs.
//   btn          raw asynchronous buttons, active-high
//   btn_level    debounced level
//   btn_posedge  one-cycle pulse on accepted 0->1
//   btn_negedge  one-cycle pulse on accepted 1->0
//   btn_repeat   one-cycle auto-repeat pulse (0 unless BTN_DEBOUNCE_REPEAT_EN)
// Modports: master = board/consumer side, slave = debouncer.
// -----------------------------------------------------------------------------
interface btn_debounce_array_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_posedge;
    logic [N_CH-1:0] btn_negedge;
    logic [N_CH-1:0] btn_repeat;

    modport master (
        output btn,
        input  btn_level,
        input  btn_posedge,
        input  btn_negedge,
        input  btn_repeat
    );

    modport slave (
        input  btn,
        output btn_level,
        output btn_posedge,
        output btn_negedge,
        output btn_repeat
    );
endinterface

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: 2-flop synchroniser, confirmation counter, 4-state FSM,
// registered press/release pulses and (with BTN_DEBOUNCE_REPEAT_EN) an
// auto-repeat generator active while the debounced level is high.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_btn        raw asynchronous button
//   o_level      debounced level
//   o_posedge    one-cycle pulse on accepted press
//   o_negedge    one-cycle pulse on accepted release
//   o_repeat     one-cycle auto-repeat pulse (tied 0 without the macro)
//
// state        | meaning
// IDLE_LOW     | level 0, synchronised input agrees
// CONFIRM_HIGH | level 0, input has been 1 for fewer than STABLE_CYCLES cycles
// IDLE_HIGH    | level 1, synchronised input agrees
// CONFIRM_LOW  | level 1, input has been 0 for fewer than STABLE_CYCLES cycles
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned REP_W         = DEF_REP_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_posedge,
    output logic o_negedge,
    output logic o_repeat
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    ch_state_t        r_state;
    ch_state_t        w_state_next;
    logic             r_pos;
    logic             r_neg;

    logic w_level;
    logic w_disagree;
    logic w_term;
    logic w_accept;
    logic w_rep;

    assign w_level    = state_level(r_state);
    assign w_disagree = (r_sync2 != w_level);
    assign w_term     = (r_cnt == CNT_TERM);
    // With STABLE_CYCLES=1 the terminal value is 0, so a single disagreeing
    // sample is accepted straight from an IDLE state.
    assign w_accept   = w_disagree && w_term;

    // State register, synchroniser, counter and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE_LOW;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            // Clearing at the terminal value keeps the counter from ever wrapping.
            if (!w_disagree || w_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pos <= w_accept && !w_level;
            r_neg <= w_accept && w_level;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE_LOW: begin
                if (w_accept)        w_state_next = IDLE_HIGH;
                else if (w_disagree) w_state_next = CONFIRM_HIGH;
            end
            CONFIRM_HIGH: begin
                if (!w_disagree)     w_state_next = IDLE_LOW;
                else if (w_accept)   w_state_next = IDLE_HIGH;
            end
            IDLE_HIGH: begin
                if (w_accept)        w_state_next = IDLE_LOW;
                else if (w_disagree) w_state_next = CONFIRM_LOW;
            end
            CONFIRM_LOW: begin
                if (!w_disagree)     w_state_next = IDLE_HIGH;
                else if (w_accept)   w_state_next = IDLE_LOW;
            end
            default: w_state_next = IDLE_LOW;
        endcase
    end

    // Outputs
    always_comb begin
        o_level   = w_level;
        o_posedge = r_pos;
        o_negedge = r_neg;
        o_repeat  = w_rep;
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam logic [REP_W-1:0] HOLD_TERM   = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REPEAT_TERM = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_first;
    logic             r_rep;
    logic [REP_W-1:0] w_rep_term;

    assign w_rep_term = r_rep_first ? HOLD_TERM : REPEAT_TERM;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
            r_rep       <= 1'b0;
        end else if (!w_level || w_accept) begin
            // Idle while released; the press-acceptance edge restarts the hold
            // phase and the release-acceptance edge stops it without a pulse.
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
            r_rep       <= 1'b0;
        end else if (r_rep_cnt == w_rep_term) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
            r_rep       <= 1'b1;
        end else begin
            r_rep_cnt   <= r_rep_cnt + REP_W'(1);
            r_rep       <= 1'b0;
        end
    end

    assign w_rep = r_rep;
`else
    logic w_unused_rep_cfg;
    assign w_unused_rep_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES, REP_W};
    assign w_rep = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_array.sv
// -----------------------------------------------------------------------------
// btn_debounce_array
// N_CH independent push-button debouncers in the system clock domain.
// Each channel is a debounce_channel instance; outputs are concatenated
// channel-by-channel onto the interface vectors.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   btn_debounce_array_if.slave (btn in; level/posedge/negedge/repeat out)
// Optional feature macro: BTN_DEBOUNCE_REPEAT_EN (auto-repeat pulses).
// CNT_W must satisfy 2^CNT_W >= STABLE_CYCLES; REP_W must hold
// max(HOLD_CYCLES, REPEAT_CYCLES).
// -----------------------------------------------------------------------------
module btn_debounce_array
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = DEF_N_CH,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned REP_W         = DEF_REP_W
) (
    input logic            clk,
    input logic            rst,
    btn_debounce_array_if.slave bus
);

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_pos;
    logic [N_CH-1:0] w_neg;
    logic [N_CH-1:0] w_rep;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REP_W         (REP_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_btn     (bus.btn[gi]),
            .o_level   (w_level[gi]),
            .o_posedge (w_pos[gi]),
            .o_negedge (w_neg[gi]),
            .o_repeat  (w_rep[gi])
        );
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_posedge = w_pos;
    assign bus.btn_negedge = w_neg;
    assign bus.btn_repeat  = w_rep;

endmodule

// File: tb/tb_btn_debounce_array.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_array
// Directed scenarios followed by randomized button traffic, every cycle checked
// against a history-window reference model: a channel accepts a new level at
// edge n when the last STABLE_CYCLES synchronised samples (raw input delayed
// two edges) all differ from the current level and no acceptance or reset
// happened within that window. Repeat pulses follow from the press edge by
// plain arithmetic.
// -----------------------------------------------------------------------------
module tb_btn_debounce_array;

    localparam int NCH    = 2;
    localparam int S      = 4;
    localparam int H      = 8;
    localparam int R      = 3;
    localparam int HIST_N = 4096;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    btn_debounce_array_if #(.N_CH(NCH)) bus ();

    btn_debounce_array #(
        .N_CH          (NCH),
        .STABLE_CYCLES (S),
        .CNT_W         (3),
        .HOLD_CYCLES   (H),
        .REPEAT_CYCLES (R),
        .REP_W         (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // reference model state
    int             edge_n = 0;
    logic [NCH-1:0] hist [HIST_N];
    int             last_rst = 0;
    logic [NCH-1:0] m_level = '0;
    int             last_acc   [NCH];
    int             press_edge [NCH];
    logic [NCH-1:0] exp_pos, exp_neg, exp_rep;

    // per-phase statistics
    int pos_cnt [NCH];
    int neg_cnt [NCH];
    int rep_cnt [NCH];
    int first_pos [NCH];
    int first_neg [NCH];
    int first_rep [NCH];
    int saw_both;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic sample(input int n, input int ch);
        if (n - 2 > last_rst) return hist[n-2][ch];
        return 1'b0;
    endfunction

    task automatic model_step(input logic r);
        bit acc;
        int d;
        exp_pos = '0;
        exp_neg = '0;
        exp_rep = '0;
        if (r) begin
            last_rst = edge_n;
            m_level  = '0;
            for (int ch = 0; ch < NCH; ch++) last_acc[ch] = edge_n;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                acc = (edge_n - last_acc[ch] >= S);
                for (int k = 0; k < S; k++)
                    if (acc && sample(edge_n - k, ch) == m_level[ch]) acc = 1'b0;
                if (REP_EN && m_level[ch] && !acc) begin
                    d = edge_n - press_edge[ch];
                    if (d == H || (d > H && (d - H) % R == 0)) exp_rep[ch] = 1'b1;
                end
                if (acc) begin
                    m_level[ch]  = ~m_level[ch];
                    last_acc[ch] = edge_n;
                    if (m_level[ch]) begin
                        exp_pos[ch]    = 1'b1;
                        press_edge[ch] = edge_n;
                    end else begin
                        exp_neg[ch] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic clear_stats();
        for (int ch = 0; ch < NCH; ch++) begin
            pos_cnt[ch] = 0; neg_cnt[ch] = 0; rep_cnt[ch] = 0;
            first_pos[ch] = -1; first_neg[ch] = -1; first_rep[ch] = -1;
        end
        saw_both = 0;
    endtask

    task automatic tick(input logic [NCH-1:0] b, input logic r);
        @(negedge clk);
        bus.btn = b;
        rst     = r;
        @(posedge clk);
        edge_n++;
        if (edge_n >= HIST_N) begin
            $display("FAIL hist_overflow observed %0d expected below %0d", edge_n, HIST_N);
            $fatal(1, "history overflow");
        end
        hist[edge_n] = b;
        model_step(r);
        #1;
        chk($sformatf("level@%0d", edge_n),   32'(bus.btn_level),   32'(m_level));
        chk($sformatf("posedge@%0d", edge_n), 32'(bus.btn_posedge), 32'(exp_pos));
        chk($sformatf("negedge@%0d", edge_n), 32'(bus.btn_negedge), 32'(exp_neg));
        chk($sformatf("repeat@%0d", edge_n),  32'(bus.btn_repeat),  32'(exp_rep));
        for (int ch = 0; ch < NCH; ch++) begin
            if (bus.btn_posedge[ch]) begin
                pos_cnt[ch]++;
                if (first_pos[ch] < 0) first_pos[ch] = edge_n;
            end
            if (bus.btn_negedge[ch]) begin
                neg_cnt[ch]++;
                if (first_neg[ch] < 0) first_neg[ch] = edge_n;
            end
            if (bus.btn_repeat[ch]) begin
                rep_cnt[ch]++;
                if (first_rep[ch] < 0) first_rep[ch] = edge_n;
            end
        end
        if (bus.btn_posedge == 2'b11) saw_both++;
    endtask

    task automatic run(input logic [NCH-1:0] b, input int n);
        for (int i = 0; i < n; i++) tick(b, 1'b0);
    endtask

    initial begin
        int             e0;
        int             gap;
        logic [8:0]     bounce;
        logic [NCH-1:0] rb;
        int             remain [NCH];

        rst     = 1'b1;
        bus.btn = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            last_acc[ch] = 0;
            press_edge[ch] = 0;
        end
        clear_stats();

        // reset
        for (int i = 0; i < 3; i++) tick(2'b00, 1'b1);
        chk("reset_level", 32'(bus.btn_level), 0);
        chk("reset_pulses", 32'({bus.btn_posedge, bus.btn_negedge, bus.btn_repeat}), 0);

        // clean press on channel 0
        clear_stats();
        e0 = edge_n;
        run(2'b01, 20);
        chk("clean_pos_count", pos_cnt[0], 1);
        chk("clean_pos_edge", first_pos[0] - e0, 6);
        chk("clean_ch1_level", 32'(bus.btn_level[1]), 0);
        run(2'b00, 10);

        // bounce on channel 0
        bounce = 9'b111101101;
        clear_stats();
        e0 = edge_n;
        for (int i = 0; i < 9; i++) tick({1'b0, bounce[i]}, 1'b0);
        run(2'b01, 6);
        chk("bounce_pos_count", pos_cnt[0], 1);
        chk("bounce_pos_edge", first_pos[0] - e0, 11);
        run(2'b00, 10);

        // short release glitch on channel 1, then real release
        run(2'b10, 8);
        chk("ch1_pressed", 32'(bus.btn_level[1]), 1);
        clear_stats();
        run(2'b00, 3);
        run(2'b10, 6);
        chk("glitch_no_neg", neg_cnt[1], 0);
        clear_stats();
        e0 = edge_n;
        run(2'b00, 10);
        chk("release_neg_count", neg_cnt[1], 1);
        chk("release_neg_edge", first_neg[1] - e0, 6);

        // reset in the middle of confirmation
        run(2'b01, 3);
        tick(2'b01, 1'b1);
        chk("midrst_level", 32'(bus.btn_level), 0);
        chk("midrst_pulses", 32'({bus.btn_posedge, bus.btn_negedge, bus.btn_repeat}), 0);
        clear_stats();
        e0 = edge_n;
        run(2'b01, 10);
        chk("midrst_pos_edge", first_pos[0] - e0, 6);
        run(2'b00, 10);

        // simultaneous press on both channels
        clear_stats();
        run(2'b11, 8);
        chk("simul_both", saw_both, 1);
        chk("simul_pos1", pos_cnt[1], 1);
        run(2'b00, 10);

        // long hold for auto-repeat
        clear_stats();
        e0 = edge_n;
        run(2'b01, 30);
        run(2'b00, 10);
        gap = (first_rep[0] < 0) ? -1 : first_rep[0] - first_pos[0];
        chk("repeat_count", rep_cnt[0], REP_EN ? 8 : 0);
        chk("repeat_first_gap", gap, REP_EN ? H : -1);
        chk("repeat_ch1", rep_cnt[1], 0);
        chk("repeat_neg_edge", first_neg[0] - e0, 36);

        // randomized bouncy traffic with occasional resets
        rb = '0;
        for (int ch = 0; ch < NCH; ch++) remain[ch] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (remain[ch] == 0) begin
                    rb[ch] = 1'($urandom_range(1, 0));
                    remain[ch] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 5))
                                                             : int'($urandom_range(6, 1));
                end
                remain[ch]--;
            end
            tick(rb, ($urandom_range(199, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
